alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 153 +++++++++++++++
 tb/tb_alu_issue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// ALU issue stage: decodes ALU-class instructions at accept time and buffers
// the decoded operands/control in a 2-entry FIFO feeding the ALU.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  acl,
  output logic [4:0]  out_rd,
  output logic        illegal
);

  typedef enum logic [3:0] {
    ACL_ADD = 4'b0000,
    ACL_SUB = 4'b0001,
    ACL_SLL = 4'b0010,
    ACL_SLT = 4'b0011,
    ACL_XOR = 4'b0100,
    ACL_SRL = 4'b0101,
    ACL_OR  = 4'b0110,
    ACL_AND = 4'b0111
  } acl_e;

  typedef enum logic [6:0] {
    OP_R = 7'b0110011,
    OP_I = 7'b0010011
  } opcode_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  acl;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  entry_t      dec;
  entry_t      mem_q [2];
  entry_t      head;
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic [1:0]  count_q, count_d;
  logic        push, pop;
  logic        is_r, is_i;
  logic [31:0] opb;

  // Decode the incoming instruction into ALU operands and control
  always_comb begin
    dec         = '0;
    dec.rd      = rd;
    dec.illegal = 1'b1;
    is_r        = (opcode == OP_R);
    is_i        = (opcode == OP_I);
    opb         = is_r ? rs2_data : imm;
    if (is_r || is_i) begin
      dec.illegal = 1'b0;
      dec.a       = rs1_data;
      dec.b       = opb;
      unique case (funct3)
        3'b000: dec.acl = (is_r && funct7_5) ? ACL_SUB : ACL_ADD;
        3'b001: begin
          dec.acl = ACL_SLL;
          dec.b   = {27'd0, opb[4:0]};
        end
        3'b010: dec.acl = ACL_SLT;
        3'b100: dec.acl = ACL_XOR;
        3'b101: begin
          dec.acl = ACL_SRL;
          dec.b   = {27'd0, opb[4:0]};
        end
        3'b110: dec.acl = ACL_OR;
        3'b111: dec.acl = ACL_AND;
        default: dec.illegal = 1'b1;
      endcase
      // sra/srai and sltu/sltiu are not handled here
      if (funct3 == 3'b101 && funct7_5) dec.illegal = 1'b1;
      if (dec.illegal) begin
        dec.a   = '0;
        dec.b   = '0;
        dec.acl = ACL_ADD;
      end
    end
  end

  assign in_ready  = rst_n && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign head      = mem_q[rptr_q];

  // Next-state for FIFO pointers and occupancy; flush overrides push/pop
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) wptr_d = ~wptr_q;
      if (pop)  rptr_d = ~rptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents only visible through the valid-gated outputs
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= dec;
  end

  // Drive payload only while the head is valid
  always_comb begin
    a       = '0;
    b       = '0;
    acl     = '0;
    out_rd  = '0;
    illegal = 1'b0;
    if (out_valid) begin
      a       = head.a;
      b       = head.b;
      acl     = head.acl;
      out_rd  = head.rd;
      illegal = head.illegal;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, funct7_5, flush, out_valid, out_ready, illegal;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, imm, a, b;
  logic [4:0]  rd, out_rd;
  logic [3:0]  acl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  acl;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .acl(acl), .out_rd(out_rd), .illegal(illegal)
  );

  // Reference decode from the instruction-set rules.
  function automatic exp_t ref_dec(input logic [6:0] op, input logic [2:0] f3,
                                   input logic f7, input logic [31:0] r1,
                                   input logic [31:0] r2, input logic [31:0] im,
                                   input logic [4:0] d);
    exp_t e;
    int   code;
    bit   rtype, itype;
    rtype = (op == 7'h33);
    itype = (op == 7'h13);
    case (int'(f3))
      0: code = (rtype && f7) ? 1 : 0;
      1: code = 2;
      2: code = 3;
      4: code = 4;
      5: code = f7 ? -1 : 5;
      6: code = 6;
      7: code = 7;
      default: code = -1;
    endcase
    if (!(rtype || itype)) code = -1;
    e.rd = d;
    if (code < 0) begin
      e.a = 0; e.b = 0; e.acl = 0; e.ill = 1'b1;
    end else begin
      e.a   = r1;
      e.b   = rtype ? r2 : im;
      if (code == 2 || code == 5) e.b = e.b % 32;
      e.acl = 4'(code);
      e.ill = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] im, input logic [4:0] d);
    in_valid = 1'b1; opcode = op; funct3 = f3; funct7_5 = f7;
    rs1_data = r1; rs2_data = r2; imm = im; rd = d;
  endtask

  // Check outputs against the model, then advance one clock and update it.
  task automatic cycle(input bit do_check);
    exp_t h;
    bit   mready, acc, pp;
    #1;
    mready = rst_n && (q.size() < 2);
    if (do_check) begin
      h = '{a: 0, b: 0, acl: 0, rd: 0, ill: 1'b0};
      if (q.size() > 0) h = q[0];
      chk("in_ready",  32'(in_ready),  32'(mready));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("a",         a,              h.a);
      chk("b",         b,              h.b);
      chk("acl",       32'(acl),       32'(h.acl));
      chk("out_rd",    32'(out_rd),    32'(h.rd));
      chk("illegal",   32'(illegal),   32'(h.ill));
    end
    acc = in_valid && mready;
    pp  = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (!rst_n || flush) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(ref_dec(opcode, funct3, funct7_5, rs1_data, rs2_data, imm, rd));
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    opcode = '0; funct3 = '0; funct7_5 = 1'b0;
    rs1_data = '0; rs2_data = '0; imm = '0; rd = '0;
    cycle(0);
    cycle(0);
    cycle(1);               // reset still asserted: in_ready must be 0
    rst_n = 1'b1;
    cycle(1);               // empty after reset

    // R add 5+3 -> rd 7, visible one cycle later
    out_ready = 1'b1;
    set_instr(7'h33, 3'b000, 1'b0, 32'd5, 32'd3, 32'd0, 5'd7);
    cycle(1);
    in_valid = 1'b0;
    #1;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_a",     a,              32'd5);
    chk("add_b",     b,              32'd3);
    chk("add_acl",   32'(acl),       32'd0);
    chk("add_rd",    32'(out_rd),    32'd7);
    cycle(1);

    // srli and sll shift-amount truncation
    set_instr(7'h13, 3'b101, 1'b0, 32'h8000_0000, 32'd0, 32'h0000_0404, 5'd1);
    cycle(1);
    chk("srli_acl", 32'(acl), 32'd5);
    chk("srli_b",   b,        32'd4);
    set_instr(7'h33, 3'b001, 1'b0, 32'd1, 32'h23, 32'd0, 5'd2);
    cycle(1);
    chk("sll_b", b, 32'd3);
    in_valid = 1'b0;
    cycle(1);

    // Back-to-back with stalled consumer, then drain in order
    out_ready = 1'b0;
    set_instr(7'h33, 3'b110, 1'b0, 32'd1, 32'd1, 32'd0, 5'd1);
    cycle(1);
    set_instr(7'h33, 3'b110, 1'b0, 32'd2, 32'd2, 32'd0, 5'd2);
    cycle(1);
    set_instr(7'h33, 3'b110, 1'b0, 32'd3, 32'd3, 32'd0, 5'd3);
    cycle(1);
    chk("full_ready", 32'(in_ready), 32'd0);
    cycle(1);
    out_ready = 1'b1;
    cycle(1);               // pops 1; third accepted next
    cycle(1);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1);

    // Illegal encodings
    set_instr(7'h33, 3'b101, 1'b1, 32'hdead, 32'hbeef, 32'd0, 5'd9);
    cycle(1);
    chk("sra_ill", 32'(illegal), 32'd1);
    set_instr(7'h03, 3'b000, 1'b0, 32'h1234, 32'h5678, 32'h9, 5'd10);
    cycle(1);
    chk("load_ill", 32'(illegal), 32'd1);
    in_valid = 1'b0;
    cycle(1);

    // Flush with two buffered and an incoming instruction
    out_ready = 1'b0;
    set_instr(7'h13, 3'b000, 1'b0, 32'd10, 32'd0, 32'd1, 5'd11);
    cycle(1);
    set_instr(7'h13, 3'b000, 1'b0, 32'd20, 32'd0, 32'd2, 5'd12);
    cycle(1);
    flush = 1'b1;
    set_instr(7'h13, 3'b000, 1'b0, 32'd30, 32'd0, 32'd3, 5'd13);
    cycle(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready),  32'd1);
    cycle(1);

    // Reset mid-operation
    set_instr(7'h33, 3'b100, 1'b0, 32'd4, 32'd5, 32'd0, 5'd14);
    cycle(1);
    cycle(1);
    in_valid = 1'b0; rst_n = 1'b0;
    cycle(1);
    rst_n = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_a",     a,              32'd0);
    set_instr(7'h33, 3'b111, 1'b0, 32'hf0, 32'h3c, 32'd0, 5'd15);
    cycle(1);
    in_valid = 1'b0;
    chk("rst_next", 32'(out_rd), 32'd15);
    cycle(1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      int unsigned sel;
      logic [11:0] im12;
      sel   = $urandom_range(0, 9);
      im12  = 12'($urandom);
      set_instr(sel < 5 ? 7'h33 : (sel < 9 ? 7'h13 : 7'($urandom)),
                3'($urandom), 1'($urandom), $urandom, $urandom,
                {{20{im12[11]}}, im12}, 5'($urandom));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      cycle(1);
    end
    in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    cycle(1);
    cycle(1);
    cycle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
